fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of the 5-bit program counter. It consumes the current pc and owns a 32-entry synchronous instruction memory. It presents fetched instructions to decode over a valid/ready handshake. It drives pc_write/new_pc back into the PC to hold it under backpressure or halt, and to redirect it on jumps signalled from execute.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_imem.sv | 23 ++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, the halt opcode and the fetch state encoding for the fetch stage.
package cpu_pkg;

  localparam int ADDR_W     = 5;
  localparam int INSTR_W    = 16;
  localparam int IMEM_DEPTH = 1 << ADDR_W;

  localparam logic [3:0] HALT_OP = 4'hF;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_imem.sv
// Instruction RAM: one synchronous read port, one write port, no reset.
module fetch_imem
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [IMEM_DEPTH];

  // Read and write share one edge; the non-blocking read returns the old word on a collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues pc into the instruction RAM, buffers returns in an output
// register plus one skid entry, and steers the PC for stalls, halt and redirects.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_write,
  output logic [ADDR_W-1:0]  new_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  fetch_state_t state, state_next;

  logic               inflight_valid;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] rdata;

  logic issue;
  logic out_free;
  logic ret_halt;

  fetch_imem u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc),
    .rdata (rdata)
  );

  // Issue is withheld whenever a return could find both out and skid occupied.
  always_comb begin
    out_free   = !out_valid || out_ready;
    ret_halt   = inflight_valid && is_halt(rdata);
    issue      = (state == RUN) && !skid_valid && !redirect_valid &&
                 !(inflight_valid && out_valid && !out_ready);
    state_next = state;
    pc_write   = 1'b0;
    new_pc     = pc;

    if (redirect_valid) begin
      state_next = RUN;
      pc_write   = 1'b1;
      new_pc     = redirect_pc;
    end else begin
      if (ret_halt) begin
        state_next = HALTED;
      end
      if (!issue) begin
        pc_write = 1'b1;
      end
    end

    if (!reset_n) begin
      pc_write = 1'b0;
      new_pc   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  assign halted = (state == HALTED);

  // A return goes to out when it is free, else to skid; a full skid always refills out first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      skid_valid     <= 1'b0;
      skid_instr     <= '0;
      skid_pc        <= '0;
      out_valid      <= 1'b0;
      out_instr      <= '0;
      out_pc         <= '0;
    end else if (redirect_valid) begin
      inflight_valid <= 1'b0;
      skid_valid     <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      inflight_valid <= issue && !ret_halt;
      if (issue) begin
        inflight_pc <= pc;
      end

      if (out_free) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_instr  <= skid_instr;
          out_pc     <= skid_pc;
          skid_valid <= inflight_valid;
          if (inflight_valid) begin
            skid_instr <= rdata;
            skid_pc    <= inflight_pc;
          end
        end else if (inflight_valid) begin
          out_valid <= 1'b1;
          out_instr <= rdata;
          out_pc    <= inflight_pc;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (inflight_valid) begin
        skid_valid <= 1'b1;
        skid_instr <= rdata;
        skid_pc    <= inflight_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// traffic, all judged by an in-order instruction-stream model of the fetch stage.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [ADDR_W-1:0]  pc;
  logic               pc_write;
  logic [ADDR_W-1:0]  new_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               halted;

  int checks = 0;
  int errors = 0;

  logic [INSTR_W-1:0] model_mem [IMEM_DEPTH];
  logic [ADDR_W-1:0]  exp_pc;
  logic [INSTR_W-1:0] prev_instr;
  logic [ADDR_W-1:0]  prev_out_pc;
  logic [ADDR_W-1:0]  held_pc;
  bit                 no_more;
  bit                 prev_hold;
  bit                 prev_redirect;
  int                 stall_cnt;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc             (pc),
    .pc_write       (pc_write),
    .new_pc         (new_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // The PC block upstream: load new_pc when told to, otherwise count up and wrap.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= '0;
    else          pc <= pc_write ? new_pc : pc + 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_clear();
    exp_pc        = '0;
    no_more       = 1'b0;
    prev_hold     = 1'b0;
    prev_redirect = 1'b0;
    stall_cnt     = 0;
  endtask

  // Stream model: accepted instructions come in consecutive address order from the
  // fetch start, carry the loaded memory word, and nothing follows a delivered halt.
  task automatic monitor();
    if (prev_redirect) begin
      check_output("flush_valid", out_valid, 1'b0);
      check_output("flush_halted", halted, 1'b0);
    end else if (prev_hold) begin
      check_output("stable_valid", out_valid, 1'b1);
      check_output("stable_instr", out_instr, prev_instr);
      check_output("stable_pc", out_pc, prev_out_pc);
    end
    if (redirect_valid) begin
      check_output("redir_pcw", pc_write, 1'b1);
      check_output("redir_newpc", new_pc, redirect_pc);
    end else if (pc_write) begin
      check_output("hold_newpc", new_pc, pc);
    end
    if (out_valid && out_instr[INSTR_W-1 -: 4] == HALT_OP)
      check_output("halt_flag", halted, 1'b1);
    if (no_more) begin
      check_output("after_halt_valid", out_valid, 1'b0);
      check_output("after_halt_pcw", pc_write, 1'b1);
    end
    if (out_valid && out_ready) begin
      check_output("order_pc", out_pc, exp_pc);
      check_output("order_instr", out_instr, model_mem[exp_pc]);
      if (model_mem[exp_pc][INSTR_W-1 -: 4] == HALT_OP && !redirect_valid) no_more = 1'b1;
      exp_pc    = exp_pc + 1'b1;
      stall_cnt = 0;
    end else if (out_ready && !halted && !redirect_valid) begin
      stall_cnt++;
    end
    if (out_ready && !halted && !redirect_valid)
      check_output("liveness", (stall_cnt <= 3) ? 1 : 0, 1);
    if (redirect_valid) begin
      exp_pc    = redirect_pc;
      no_more   = 1'b0;
      stall_cnt = 0;
    end
    prev_redirect = redirect_valid;
    prev_hold     = out_valid && !out_ready;
    prev_instr    = out_instr;
    prev_out_pc   = out_pc;
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic ready, input logic redir, input logic [ADDR_W-1:0] target);
    out_ready      = ready;
    redirect_valid = redir;
    redirect_pc    = target;
    tick();
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] addr, input logic [INSTR_W-1:0] data);
    imem_we         = 1'b1;
    imem_waddr      = addr;
    imem_wdata      = data;
    model_mem[addr] = data;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_output(tag, seen, 1'b1);
  endtask

  initial begin
    reset_n        = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_we        = 1'b0;
    imem_waddr     = '0;
    imem_wdata     = '0;
    sb_clear();
    @(negedge clk);
    for (int i = 0; i < IMEM_DEPTH; i++) load_word(ADDR_W'(i), INSTR_W'(16'h1000 + i));

    #1;
    check_output("rst_valid", out_valid, 1'b0);
    check_output("rst_instr", out_instr, 16'h0);
    check_output("rst_pc", out_pc, 5'd0);
    check_output("rst_halted", halted, 1'b0);
    check_output("rst_pcw", pc_write, 1'b0);
    check_output("rst_newpc", new_pc, 5'd0);
    @(negedge clk);

    // Streaming from address 0.
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    check_output("start_valid", out_valid, 1'b0);
    check_output("start_pcw", pc_write, 1'b0);
    tick();
    wait_valid("first_valid", 4);
    check_output("first_pc", out_pc, 5'd0);
    check_output("first_instr", out_instr, 16'h1000);
    for (int k = 0; k < 4; k++) begin
      check_output("stream_valid", out_valid, 1'b1);
      check_output("stream_pc", out_pc, k);
      check_output("stream_pcw", pc_write, 1'b0);
      tick();
    end

    // Backpressure at out_pc 4.
    #1;
    check_output("bp_at4", out_pc, 5'd4);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_output("bp_instr", out_instr, 16'h1004);
      check_output("bp_pcw", pc_write, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_output("bp_rel0", out_instr, 16'h1004);
    tick();
    #1;
    check_output("bp_rel1_valid", out_valid, 1'b1);
    check_output("bp_rel1", out_instr, 16'h1005);
    tick();
    wait_valid("bp_rel2_wait", 4);
    check_output("bp_rel2", out_instr, 16'h1006);

    // Redirect to 20 with out and skid full.
    out_ready = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 5'd20;
    #1;
    check_output("rd_pcw", pc_write, 1'b1);
    check_output("rd_newpc", new_pc, 5'd20);
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #1;
    check_output("rd_flushed", out_valid, 1'b0);
    tick();
    wait_valid("rd_wait", 4);
    check_output("rd_pc", out_pc, 5'd20);
    check_output("rd_instr", out_instr, 16'h1014);

    // Wrap from 30 through 0.
    apply_stimulus(1'b1, 1'b1, 5'd30);
    redirect_valid = 1'b0;
    wait_valid("wrap_wait", 4);
    for (int j = 0; j < 4; j++) begin
      logic [ADDR_W-1:0] e;
      e = ADDR_W'(30 + j);
      check_output("wrap_valid", out_valid, 1'b1);
      check_output("wrap_pc", out_pc, e);
      check_output("wrap_instr", out_instr, 16'h1000 + e);
      tick();
    end

    // Halt on address 6.
    reset_n = 1'b0;
    sb_clear();
    load_word(5'd6, 16'hF000);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (halted) break;
      tick();
    end
    check_output("halt_reached", halted, 1'b1);
    check_output("halt_pc", out_pc, 5'd6);
    check_output("halt_instr", out_instr, 16'hF000);
    tick();
    #1;
    held_pc = pc;
    for (int k = 0; k < 5; k++) begin
      check_output("halt_quiet", out_valid, 1'b0);
      check_output("halt_stays", halted, 1'b1);
      tick();
    end
    check_output("halt_pc_held", pc, held_pc);
    apply_stimulus(1'b1, 1'b1, 5'd2);
    redirect_valid = 1'b0;
    #1;
    check_output("unhalt", halted, 1'b0);
    wait_valid("unhalt_wait", 4);
    check_output("unhalt_pc", out_pc, 5'd2);
    check_output("unhalt_instr", out_instr, 16'h1002);

    // Asynchronous reset with out and skid full.
    out_ready = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_output("areset_valid", out_valid, 1'b0);
    check_output("areset_halted", halted, 1'b0);
    sb_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    wait_valid("areset_wait", 4);
    check_output("areset_pc", out_pc, 5'd0);
    check_output("areset_instr", out_instr, 16'h1000);

    // Randomized traffic over a random program.
    reset_n = 1'b0;
    sb_clear();
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      logic [INSTR_W-1:0] w;
      w = INSTR_W'($urandom);
      if ($urandom_range(0, 7) == 0) w[INSTR_W-1 -: 4] = HALT_OP;
      else if (w[INSTR_W-1 -: 4] == HALT_OP) w[INSTR_W-1] = 1'b0;
      load_word(ADDR_W'(i), w);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic rd;
      rd = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      apply_stimulus($urandom_range(0, 3) != 0, rd, ADDR_W'($urandom));
    end
    redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
